// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: stall vectors, FSM states
// and the bundled control-strobe record.
package hazard_ctrl_pkg;

  // stall vector bits: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
  localparam logic [5:0] STALL_NONE     = 6'b000000;
  localparam logic [5:0] STALL_LOAD_USE = 6'b000111;
  localparam logic [5:0] STALL_EX_WAIT  = 6'b001111;

  localparam logic [0:0] HZ_IDLE    = 1'b0;
  localparam logic [0:0] HZ_EX_WAIT = 1'b1;

  typedef struct packed {
    logic [5:0] stall;
    logic       ifid_clr;
    logic       idex_clr;
    logic       flush_all;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_CTRL_NONE = '{stall: STALL_NONE, ifid_clr: 1'b0,
                                        idex_clr: 1'b0, flush_all: 1'b0};

endpackage

// File: rtl/hazard_ctrl_ex_wait_timer.sv
// Watchdog for in-flight multi-cycle EX ops: counts cycles spent waiting and
// flags the last permitted wait cycle.
module hazard_ctrl_ex_wait_timer #(
  parameter int MAX_EX_CYCLES = 34,
  parameter int CNT_W         = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_EX_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // run is low on the entry edge, so the first wait cycle always sees 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: stall vector, per-stage clears, EX-wait FSM with watchdog.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_EX_CYCLES = 34,
  parameter int CNT_W         = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stallreq_i,
  input  logic        id_branch_i,
  input  logic        ex_start_i,
  input  logic        ex_done_i,
  input  logic        exc_req_i,
  output logic [5:0]  stall_o,
  output logic        ifid_clr_o,
  output logic        idex_clr_o,
  output logic        flush_all_o,
  output logic        ex_wait_o,
  output logic        err_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_flush_o
);

  // state    | meaning
  // HZ_IDLE    | no multi-cycle EX op outstanding
  // HZ_EX_WAIT | EX op issued, front end held until done or watchdog expiry

  logic [0:0] state, state_nxt;
  logic       expired, timeout, run;
  hz_ctrl_t   ctrl;

  hazard_ctrl_ex_wait_timer #(
    .MAX_EX_CYCLES(MAX_EX_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .expired(expired)
  );

  assign timeout = (state == HZ_EX_WAIT) && expired && !ex_done_i && !exc_req_i;
  assign run     = (state == HZ_EX_WAIT) && (state_nxt == HZ_EX_WAIT);

  always_comb begin
    state_nxt = state;
    if (exc_req_i) begin
      state_nxt = HZ_IDLE;
    end else if (state == HZ_IDLE) begin
      if (ex_start_i && !ex_done_i) state_nxt = HZ_EX_WAIT;
    end else if (ex_done_i || timeout) begin
      state_nxt = HZ_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HZ_IDLE;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (timeout) err_o <= 1'b1;
    end
  end

  // the done cycle and the expiry cycle fall through to the lower-priority rules
  always_comb begin
    ctrl = HZ_CTRL_NONE;
    if (exc_req_i) begin
      ctrl.ifid_clr  = 1'b1;
      ctrl.idex_clr  = 1'b1;
      ctrl.flush_all = 1'b1;
    end else if ((state == HZ_EX_WAIT) && !ex_done_i && !expired) begin
      ctrl.stall = STALL_EX_WAIT;
    end else if (id_stallreq_i) begin
      ctrl.stall = STALL_LOAD_USE;
    end else if (id_branch_i) begin
      ctrl.ifid_clr = 1'b1;
    end
  end

  assign stall_o     = rst ? STALL_NONE : ctrl.stall;
  assign ifid_clr_o  = !rst && ctrl.ifid_clr;
  assign idex_clr_o  = !rst && ctrl.idex_clr;
  assign flush_all_o = !rst && ctrl.flush_all;
  assign ex_wait_o   = (state == HZ_EX_WAIT);

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_o != STALL_NONE)       perf_stall_q <= perf_stall_q + 32'd1;
      if (ifid_clr_o || flush_all_o)   perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_flush_o = perf_flush_q;
`else
  assign perf_stall_o = 32'h0;
  assign perf_flush_o = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

  localparam int MAX_EX = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stallreq_i, id_branch_i, ex_start_i, ex_done_i, exc_req_i;
  logic [5:0]  stall_o;
  logic        ifid_clr_o, idex_clr_o, flush_all_o, ex_wait_o, err_o;
  logic [31:0] perf_stall_o, perf_flush_o;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.MAX_EX_CYCLES(MAX_EX), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_stallreq_i(id_stallreq_i),
    .id_branch_i  (id_branch_i),
    .ex_start_i   (ex_start_i),
    .ex_done_i    (ex_done_i),
    .exc_req_i    (exc_req_i),
    .stall_o      (stall_o),
    .ifid_clr_o   (ifid_clr_o),
    .idex_clr_o   (idex_clr_o),
    .flush_all_o  (flush_all_o),
    .ex_wait_o    (ex_wait_o),
    .err_o        (err_o),
    .perf_stall_o (perf_stall_o),
    .perf_flush_o (perf_flush_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: an outstanding-op flag plus how long it has been waiting
  bit          m_busy;
  int          m_age;
  bit          m_err;
  logic [31:0] m_pstall, m_pflush;
  logic [5:0]  m_stall;
  bit          m_ifid, m_idex, m_flush, m_timeout;

  always_comb begin
    m_stall   = 6'b000000;
    m_ifid    = 1'b0;
    m_idex    = 1'b0;
    m_flush   = 1'b0;
    m_timeout = m_busy && (m_age == MAX_EX - 1) && !ex_done_i && !exc_req_i;
    if (!rst) begin
      if (exc_req_i) begin
        m_ifid = 1'b1; m_idex = 1'b1; m_flush = 1'b1;
      end else if (m_busy && !ex_done_i && !m_timeout) begin
        m_stall = 6'b001111;
      end else if (id_stallreq_i) begin
        m_stall = 6'b000111;
      end else if (id_branch_i) begin
        m_ifid = 1'b1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_age <= 0; m_err <= 0; m_pstall <= '0; m_pflush <= '0;
    end else begin
      if (m_stall != 0)      m_pstall <= m_pstall + 1;
      if (m_ifid || m_flush) m_pflush <= m_pflush + 1;
      if (exc_req_i) begin
        m_busy <= 0; m_age <= 0;
      end else if (m_busy) begin
        if (ex_done_i || m_timeout) begin
          m_busy <= 0; m_age <= 0;
          if (m_timeout) m_err <= 1;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (ex_start_i && !ex_done_i) begin
        m_busy <= 1; m_age <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("stall", {26'd0, stall_o}, {26'd0, m_stall});
    chk("ifid_clr", {31'd0, ifid_clr_o}, {31'd0, m_ifid});
    chk("idex_clr", {31'd0, idex_clr_o}, {31'd0, m_idex});
    chk("flush_all", {31'd0, flush_all_o}, {31'd0, m_flush});
    chk("ex_wait", {31'd0, ex_wait_o}, {31'd0, m_busy});
    chk("err", {31'd0, err_o}, {31'd0, m_err});
`ifdef HAZARD_PERF_EN
    chk("perf_stall", perf_stall_o, m_pstall);
    chk("perf_flush", perf_flush_o, m_pflush);
`else
    chk("perf_stall_off", perf_stall_o, 32'h0);
    chk("perf_flush_off", perf_flush_o, 32'h0);
`endif
  end

  task automatic drive(input logic sr, input logic br, input logic st, input logic dn,
                       input logic ex);
    id_stallreq_i = sr; id_branch_i = br; ex_start_i = st; ex_done_i = dn; exc_req_i = ex;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  initial begin
    int n_stall;
    int n_wait;
    rst = 1'b1;
    drive(1, 1, 1, 0, 1);
    @(negedge clk);
    chk("rst_stall", {26'd0, stall_o}, 32'h0);
    chk("rst_clears", {29'd0, ifid_clr_o, idex_clr_o, flush_all_o}, 32'h0);
    next_cyc();
    drive(0, 0, 0, 0, 0);
    next_cyc();
    rst = 1'b0;

    // idle after reset
    @(negedge clk);
    chk("idle_stall", {26'd0, stall_o}, 32'h0);
    chk("idle_wait_err", {30'd0, ex_wait_o, err_o}, 32'h0);

    // load-use beats a same-cycle branch
    next_cyc(); drive(1, 1, 0, 0, 0);
    @(negedge clk);
    chk("loaduse_stall", {26'd0, stall_o}, 32'h07);
    chk("loaduse_ifid", {31'd0, ifid_clr_o}, 32'h0);
    next_cyc(); drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("loaduse_one_cycle", {26'd0, stall_o}, 32'h0);

    // EX op held for five stalled cycles, branch suppressed while waiting
    next_cyc(); drive(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("start_cycle_stall", {26'd0, stall_o}, 32'h0);
    n_stall = 0;
    for (int i = 0; i < 5; i++) begin
      next_cyc(); drive(0, (i == 2), 0, 0, 0);
      @(negedge clk);
      if (stall_o == 6'b001111) n_stall++;
      if (i == 2) chk("wait_branch_ifid", {31'd0, ifid_clr_o}, 32'h0);
    end
    chk("ex_stall_cycles", n_stall, 5);
    next_cyc(); drive(0, 1, 0, 1, 0);
    @(negedge clk);
    chk("done_stall", {26'd0, stall_o}, 32'h0);
    chk("done_branch_ifid", {31'd0, ifid_clr_o}, 32'h1);
    chk("done_ex_wait", {31'd0, ex_wait_o}, 32'h1);
    next_cyc(); drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("after_done_wait", {31'd0, ex_wait_o}, 32'h0);

    // exception during EX_WAIT from a clean reset
    next_cyc(); do_reset();
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      next_cyc(); drive(0, 0, 0, 0, 0);
    end
    next_cyc(); drive(1, 1, 1, 0, 1);
    @(negedge clk);
    chk("exc_stall", {26'd0, stall_o}, 32'h0);
    chk("exc_clears", {29'd0, ifid_clr_o, idex_clr_o, flush_all_o}, 32'h7);
    next_cyc(); drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("exc_next_wait", {31'd0, ex_wait_o}, 32'h0);
`ifdef HAZARD_PERF_EN
    chk("exc_perf_stall", perf_stall_o, 32'd4);
    chk("exc_perf_flush", perf_flush_o, 32'd1);
`endif

    // watchdog: 33 stalled cycles, release on the 34th, sticky err
    next_cyc(); drive(0, 0, 1, 0, 0);
    n_stall = 0;
    n_wait  = 0;
    for (int i = 0; i < 40; i++) begin
      next_cyc(); drive(0, 0, 0, 0, 0);
      @(negedge clk);
      if (stall_o != 6'b000000) n_stall++;
      if (ex_wait_o) n_wait++;
    end
    chk("wd_stall_cycles", n_stall, 33);
    chk("wd_wait_cycles", n_wait, 34);
    chk("wd_err", {31'd0, err_o}, 32'h1);

    // async reset in the middle of EX_WAIT
    next_cyc(); drive(0, 0, 1, 0, 0);
    next_cyc(); drive(0, 0, 0, 0, 0);
    next_cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wait", {31'd0, ex_wait_o}, 32'h0);
    chk("midrst_stall", {26'd0, stall_o}, 32'h0);
    chk("midrst_err", {31'd0, err_o}, 32'h0);
    next_cyc();
    rst = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      next_cyc();
      drive(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
            ($urandom % 25) == 0, ($urandom % 60) == 0);
      if (i == 1500 || i == 1501) rst = 1'b1;
      else rst = 1'b0;
    end
    next_cyc(); drive(0, 0, 0, 0, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
